cache_req_driver: RTL and testbench
===================================

Name: cache_req_driver

Overview:
- Clocked request front-end sitting directly upstream of the cache/memory data bus (cache_1b plus memory top).
- Accepts CPU load/store requests on a valid/ready handshake and buffers them in a small FIFO.
- Presents one request at a time on the combinational bus (isRead/address/writeData), holds it stable for a settle window, samples readData/isHit and returns a response on a second valid/ready handshake.
- Keeps hit/miss statistics.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
SETTLE_CYCLES, 1, cycles bus inputs are held stable before sampling (>=1)
ADDR_W, 10, byte address width of the bus
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
reqValid  input  1  CPU request valid
reqReady  output  1  FIFO can accept; equals !full
reqIsRead  input  1  1 = load, 0 = store
reqAddress  input  ADDR_W  request address
reqWriteData  input  DATA_W  store data
busIsRead  output  1  to data bus isRead
busAddress  output  ADDR_W  to data bus address
busWriteData  output  DATA_W  to data bus writeData
busReadData  input  DATA_W  from data bus readData
busIsHit  input  1  from data bus isHit
respValid  output  1  response available
respReady  input  1  CPU takes response
respReadData  output  DATA_W  sampled readData (stores: sampled value, don't-care)
respIsHit  output  1  sampled isHit
respIsRead  output  1  echo of request type
hitCount  output  16  saturating hit counter
missCount  output  16  saturating miss counter

Behaviour:
- Reset (async, any state): FIFO emptied, state IDLE, busIsRead=1, busAddress=0, busWriteData=0, respValid=0, respReadData=0, respIsHit=0, respIsRead=0, counters=0. In-flight and queued requests are discarded; reqReady=1 once reset deasserts.
- Push: reqValid && reqReady at an edge writes {isRead, address, writeData} into the FIFO. Push and pop in the same cycle are allowed.
- Bus outputs are registers and change only when a request is popped or on reset. Between requests the last address is held with busIsRead forced to 1, so a store is never re-applied.
- FSM:
  - IDLE: FIFO non-empty -> pop, load bus registers, counter=SETTLE_CYCLES-1, go ISSUE.
  - ISSUE: counter!=0 -> decrement. counter==0 -> sample busReadData/busIsHit into resp regs, set respValid=1, update counters, go RESP. At the sampling edge busIsRead returns to 1.
  - RESP: respValid holds (data stable) until respReady. On the handshake edge, if FIFO non-empty pop directly into ISSUE (respValid=0), else go IDLE.
- Latency: request accepted at edge E0 -> popped at E1 -> respValid high after edge E1+SETTLE_CYCLES.
- Throughput with respReady tied high: one response per SETTLE_CYCLES+1 cycles.
- Capacity with respReady=0: FIFO_DEPTH queued plus 1 in RESP.
- Counters: a hit increments hitCount, a miss increments missCount; loads and stores both count. Each counter saturates at 0xFFFF without wrap.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. full/empty are decoded from MSB mismatch/equality; wrap-around is natural.

Optional Feature:
- Macro: CACHE_REQ_STATS_EN.
- Defined: hitCount/missCount behave as above.
- Undefined: counter registers are not built and hitCount/missCount are tied to 0. All other behaviour is identical.

Test Plan:
- After reset, read 0x100, respReady=1 -> respValid after 2 cycles, respIsHit=0, missCount=1.
- Store 0x12345678 to 0x040, then load 0x040 -> second response respReadData=0x12345678, respIsHit=1, respIsRead=1.
- respReady=0, reqValid held high -> exactly 5 requests accepted, then reqReady=0. Release respReady -> responses return in order, addresses match, FIFO drains.
- respReady=1, 8 back-to-back loads to 0x000..0x01C, SETTLE_CYCLES=1 -> 8 responses, one every 2 cycles, hitCount+missCount=8.
- Assert rst during ISSUE with 3 queued -> immediately respValid=0, busIsRead=1, busAddress=0, counters=0, reqReady=1 after deassert; no stale response appears.
- Build without CACHE_REQ_STATS_EN, run scenario 4 -> hitCount=missCount=0 throughout; responses identical to the enabled build.

Source files
------------

// File: rtl/cache_req_driver.sv
// cache_req_driver: request front-end for the combinational cache/memory data bus.
// CPU requests are queued in a small FIFO, applied to the bus one at a time,
// held for SETTLE_CYCLES, sampled, and returned on a response handshake.
// Optional hit/miss statistics are built only when CACHE_REQ_STATS_EN is defined;
// otherwise hitCount/missCount are tied to zero.
module cache_req_driver #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqIsRead,
    input  logic [ADDR_W-1:0] reqAddress,
    input  logic [DATA_W-1:0] reqWriteData,
    output logic              busIsRead,
    output logic [ADDR_W-1:0] busAddress,
    output logic [DATA_W-1:0] busWriteData,
    input  logic [DATA_W-1:0] busReadData,
    input  logic              busIsHit,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respReadData,
    output logic              respIsHit,
    output logic              respIsRead,
    output logic [15:0]       hitCount,
    output logic [15:0]       missCount
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;
    logic               head_is_read;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign reqReady = !full;
    assign push     = reqValid && !full;

    assign head         = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign head_is_read = head[ENTRY_W-1];
    assign head_addr    = head[DATA_W +: ADDR_W];
    assign head_wdata   = head[DATA_W-1:0];

    // Write the incoming request into the slot addressed by the write pointer.
    // NOTE: storage is deliberately not reset; the pointers alone say which slots hold live data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= {reqIsRead, reqAddress, reqWriteData};
        end
    end

    // Pointer advance; wrap-around falls out of the natural binary overflow.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // ------------------------------------------------------ issue/response FSM
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_is_read_q, bus_is_read_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic               resp_hit_q, resp_hit_d;
    logic               resp_is_read_q, resp_is_read_d;

    // Next-state, pop decision and bus/response register updates.
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pop            = 1'b0;
        bus_is_read_d  = bus_is_read_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_hit_d     = resp_hit_q;
        resp_is_read_d = resp_is_read_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_valid_d   = 1'b1;
                    resp_rdata_d   = busReadData;
                    resp_hit_d     = busIsHit;
                    // bus_is_read_q still carries the request type until this edge.
                    resp_is_read_d = bus_is_read_q;
                    // Park the bus as a read so a store is never applied twice.
                    bus_is_read_d  = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (respReady) begin
                    resp_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop is the only event that drives a new request onto the bus.
        if (pop) begin
            bus_is_read_d = head_is_read;
            bus_addr_d    = head_addr;
            bus_wdata_d   = head_wdata;
            cnt_d         = CNT_W'(SETTLE_CYCLES - 1);
        end
    end

    // State, pointer, bus and response registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            bus_is_read_q  <= 1'b1;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_hit_q     <= 1'b0;
            resp_is_read_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            bus_is_read_q  <= bus_is_read_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_hit_q     <= resp_hit_d;
            resp_is_read_q <= resp_is_read_d;
        end
    end

    assign busIsRead    = bus_is_read_q;
    assign busAddress   = bus_addr_q;
    assign busWriteData = bus_wdata_q;
    assign respValid    = resp_valid_q;
    assign respReadData = resp_rdata_q;
    assign respIsHit    = resp_hit_q;
    assign respIsRead   = resp_is_read_q;

    // ---------------------------------------------------------- statistics
`ifdef CACHE_REQ_STATS_EN
    logic        sample;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    assign sample = (state_q == ISSUE) && (cnt_q == '0);

    // Saturating hit/miss counters, bumped on the bus sampling edge.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (sample) begin
            if (busIsHit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_cache_req_driver.sv
// Testbench for cache_req_driver: a behavioural direct-mapped cache/memory
// drives the bus, a reference model predicts every response at push time,
// and a monitor pops and compares on each response handshake.
`timescale 1ns/1ps
module tb_cache_req_driver;

    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 32;
    localparam int FIFO_DEPTH    = 4;
    localparam int SETTLE_CYCLES = 1;
    localparam int LINES         = 8;
    localparam int WORDS         = 256;
`ifdef CACHE_REQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              reqValid, reqReady, reqIsRead;
    logic [ADDR_W-1:0] reqAddress;
    logic [DATA_W-1:0] reqWriteData;
    logic              busIsRead;
    logic [ADDR_W-1:0] busAddress;
    logic [DATA_W-1:0] busWriteData;
    logic [DATA_W-1:0] busReadData = '0;
    logic              busIsHit = 1'b0;
    logic              respValid, respReady;
    logic [DATA_W-1:0] respReadData;
    logic              respIsHit, respIsRead;
    logic [15:0]       hitCount, missCount;

    cache_req_driver #(
        .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqIsRead(reqIsRead),
        .reqAddress(reqAddress), .reqWriteData(reqWriteData),
        .busIsRead(busIsRead), .busAddress(busAddress), .busWriteData(busWriteData),
        .busReadData(busReadData), .busIsHit(busIsHit),
        .respValid(respValid), .respReady(respReady),
        .respReadData(respReadData), .respIsHit(respIsHit), .respIsRead(respIsRead),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two copies of the cache/memory environment: copy 0 is the reference
    // model advanced in request order at push time, copy 1 is the live bus
    // responder advanced when the CPU takes each response.
    bit                vld_a [2][LINES];
    int                tag_a [2][LINES];
    logic [DATA_W-1:0] mem_a [2][WORDS];

    function automatic void env_clear(int c);
        for (int i = 0; i < LINES; i++) begin
            vld_a[c][i] = 1'b0;
            tag_a[c][i] = 0;
        end
        for (int w = 0; w < WORDS; w++) mem_a[c][w] = 32'hC0DE_0000 + DATA_W'(w * 3);
    endfunction

    function automatic bit env_hit(int c, logic [ADDR_W-1:0] a);
        int w = int'(a) / 4;
        return vld_a[c][w % LINES] && (tag_a[c][w % LINES] == w / LINES);
    endfunction

    function automatic void env_touch(int c, bit rd, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        int w = int'(a) / 4;
        if (!rd) mem_a[c][w] = d;
        vld_a[c][w % LINES] = 1'b1;
        tag_a[c][w % LINES] = w / LINES;
    endfunction

    typedef struct {
        bit                is_read;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        bit                hit;
    } exp_t;

    exp_t exp_q[$];
    int   exp_hits = 0;
    int   exp_misses = 0;

    function automatic void model_push(bit rd, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        exp_t e;
        e.is_read = rd;
        e.addr    = a;
        e.wdata   = d;
        e.rdata   = mem_a[0][int'(a) / 4];
        e.hit     = env_hit(0, a);
        env_touch(0, rd, a, d);
        exp_q.push_back(e);
    endfunction

    // Bus responder: combinational cache view, refreshed between clock edges.
    always @(negedge clk) begin
        #1;
        busReadData = mem_a[1][int'(busAddress) / 4];
        busIsHit    = env_hit(1, busAddress);
    end

    // Monitor: compare each response as the CPU takes it.
    exp_t              mon_e;
    logic [DATA_W-1:0] last_rdata = '0;
    bit                last_hit = 1'b0;
    bit                last_is_read = 1'b0;
    int                hs_cycles[$];

    always @(negedge clk) begin
        if (respValid === 1'b1 && respReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got a response expected none (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_is_read", respIsRead, mon_e.is_read);
                if (mon_e.is_read) check("resp_read_data", respReadData, mon_e.rdata);
                check("resp_is_hit", respIsHit, mon_e.hit);
                check("bus_address_held", busAddress, mon_e.addr);
                check("bus_write_data_held", busWriteData, mon_e.wdata);
                check("bus_is_read_parked", busIsRead, 1'b1);
                if (mon_e.hit) exp_hits++;
                else           exp_misses++;
                check("hit_count", hitCount, STATS ? exp_hits : 0);
                check("miss_count", missCount, STATS ? exp_misses : 0);
                last_rdata   = respReadData;
                last_hit     = respIsHit;
                last_is_read = respIsRead;
                hs_cycles.push_back(cycle);
            end
            env_touch(1, respIsRead, busAddress, busWriteData);
        end
    end

    // ------------------------------------------------------------ stimulus
    bit bp_random = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_random) respReady = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'($urandom_range(0, 31) * 4);
    endfunction

    task automatic send(bit rd, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        int waited = 0;
        reqValid = 1'b1; reqIsRead = rd; reqAddress = a; reqWriteData = d;
        while (!reqReady && waited < 200) begin
            tick();
            waited++;
        end
        if (!reqReady) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: reqReady stuck at 0 for %0d cycles", waited);
            reqValid = 1'b0;
            return;
        end
        model_push(rd, a, d);
        tick();
        reqValid = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        bp_random = 1'b0;
        respReady = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int accepted;
        int base;
        rst = 1'b1; reqValid = 1'b0; reqIsRead = 1'b1; reqAddress = '0; reqWriteData = '0;
        respReady = 1'b0;
        env_clear(0);
        env_clear(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", respValid, 1'b0);
        check("rst_bus_is_read", busIsRead, 1'b1);
        check("rst_bus_address", busAddress, 0);
        check("rst_bus_write_data", busWriteData, 0);
        check("rst_resp_read_data", respReadData, 0);
        check("rst_resp_is_hit", respIsHit, 1'b0);
        check("rst_resp_is_read", respIsRead, 1'b0);
        check("rst_hit_count", hitCount, 0);
        check("rst_miss_count", missCount, 0);
        rst = 1'b0;
        tick();
        check("rst_req_ready", reqReady, 1'b1);

        // Single load from a cold cache: accepted at E0, valid after E0+2.
        respReady = 1'b1;
        send(1'b1, 10'h100, '0);
        check("lat_after_accept", respValid, 1'b0);
        tick();
        check("lat_after_pop", respValid, 1'b0);
        tick();
        check("lat_after_sample", respValid, 1'b1);
        check("first_is_hit", respIsHit, 1'b0);
        check("first_miss_count", missCount, STATS ? 1 : 0);
        drain(20);

        // Store then load to the same address.
        send(1'b0, 10'h040, 32'h1234_5678);
        send(1'b1, 10'h040, '0);
        drain(40);
        check("st_ld_data", last_rdata, 32'h1234_5678);
        check("st_ld_hit", last_hit, 1'b1);
        check("st_ld_is_read", last_is_read, 1'b1);

        // Capacity with the response path stalled.
        respReady = 1'b0;
        accepted = 0;
        reqValid = 1'b1;
        reqIsRead = 1'($urandom_range(0, 1)); reqAddress = rand_addr(); reqWriteData = $urandom;
        for (int i = 0; i < 12; i++) begin
            if (reqReady) begin
                model_push(reqIsRead, reqAddress, reqWriteData);
                accepted++;
            end
            tick();
            reqIsRead = 1'($urandom_range(0, 1)); reqAddress = rand_addr(); reqWriteData = $urandom;
        end
        reqValid = 1'b0;
        check("cap_accepted", accepted, FIFO_DEPTH + 1);
        check("cap_req_ready", reqReady, 1'b0);
        drain(100);

        // Back-to-back loads with respReady high: one response per 2 cycles.
        base = exp_hits + exp_misses;
        hs_cycles.delete();
        respReady = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b1, ADDR_W'(i * 4), '0);
        drain(100);
        check("tp_responses", hs_cycles.size(), 8);
        for (int i = 1; i < hs_cycles.size(); i++)
            check("tp_interval", hs_cycles[i] - hs_cycles[i-1], SETTLE_CYCLES + 1);
        check("tp_total", hitCount + missCount, STATS ? base + 8 : 0);

        // Reset while a request is in ISSUE with three more queued.
        respReady = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, ADDR_W'(12'h200 + i * 4), '0);
        respReady = 1'b1;
        tick();
        rst = 1'b1;
        exp_q.delete();
        env_clear(0);
        env_clear(1);
        exp_hits = 0;
        exp_misses = 0;
        #1;
        check("mid_rst_resp_valid", respValid, 1'b0);
        check("mid_rst_bus_is_read", busIsRead, 1'b1);
        check("mid_rst_bus_address", busAddress, 0);
        check("mid_rst_hit_count", hitCount, 0);
        check("mid_rst_miss_count", missCount, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", reqReady, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("no_stale_resp", respValid, 1'b0);
            tick();
        end

        // Randomized traffic with random backpressure and idle gaps.
        bp_random = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
